// File: rtl/lsu_ld_collect_if.sv
// Bundle of the command, AXI read-data, load-buffer write and status signals
// for the load-collect block. The slave modport is the collector's view; the
// master modport is the view of whatever surrounds it.
interface lsu_ld_collect_if #(
  parameter int DW     = 64,
  parameter int DST_AW = 10
);
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [DST_AW-1:0] cmd_dst_addr;
  logic [DST_AW-1:0] cmd_dst_str;
  logic [7:0]        cmd_beats;

  logic [7:0]        axi_lsu_rid;
  logic [DW-1:0]     axi_lsu_rdata;
  logic [1:0]        axi_lsu_rresp;
  logic              axi_lsu_rlast;
  logic              axi_lsu_rvld;
  logic              lsu_axi_rrdy;

  logic              buf_wr_en;
  logic [DST_AW-1:0] buf_wr_addr;
  logic [DW-1:0]     buf_wr_data;
  logic              buf_wr_rdy;

  logic              ld_done;
  logic              ld_err;
  logic [1:0]        ld_err_resp;
  logic [7:0]        ld_beat_cnt;

  modport slave (
    input  cmd_vld, cmd_dst_addr, cmd_dst_str, cmd_beats,
    input  axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld,
    input  buf_wr_rdy,
    output cmd_rdy, lsu_axi_rrdy,
    output buf_wr_en, buf_wr_addr, buf_wr_data,
    output ld_done, ld_err, ld_err_resp, ld_beat_cnt
  );

  modport master (
    output cmd_vld, cmd_dst_addr, cmd_dst_str, cmd_beats,
    output axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld,
    output buf_wr_rdy,
    input  cmd_rdy, lsu_axi_rrdy,
    input  buf_wr_en, buf_wr_addr, buf_wr_data,
    input  ld_done, ld_err, ld_err_resp, ld_beat_cnt
  );
endinterface

// File: rtl/lsu_ld_collect.sv
// Load-data collector: accepts AXI read beats for one load command at a time,
// buffers them in a small FIFO and writes them into the load buffer at a
// strided address. Reports done pulse, written beat count and sticky error.
module lsu_ld_collect #(
  parameter int DW         = 64,
  parameter int DST_AW     = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  lsu_ld_collect_if.slave   bus
);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]  ONE_CNT  = (PTR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

  state_t            state;
  logic [DST_AW-1:0] dst_str;
  logic [DST_AW-1:0] wr_addr;
  logic [7:0]        beats;
  logic [7:0]        acc_cnt;
  logic [7:0]        beat_cnt;
  logic              err;
  logic [1:0]        err_resp;

  logic [DW-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W:0]    count;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic cmd_acc;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign cmd_acc    = bus.cmd_vld & (state == IDLE);

  // Full FIFO refuses a beat even when the head is being written this cycle,
  // which keeps the ready path free of the buffer's ready.
  assign bus.cmd_rdy      = (state == IDLE);
  assign bus.lsu_axi_rrdy = (state == RECV) & ~fifo_full & (acc_cnt < beats);
  assign push             = bus.axi_lsu_rvld & bus.lsu_axi_rrdy;
  assign pop              = ~fifo_empty & bus.buf_wr_rdy;

  assign bus.buf_wr_en    = ~fifo_empty;
  assign bus.buf_wr_addr  = wr_addr;
  assign bus.buf_wr_data  = mem[rptr];
  assign bus.ld_done      = (state == DONE);
  assign bus.ld_err       = err;
  assign bus.ld_err_resp  = err_resp;
  assign bus.ld_beat_cnt  = beat_cnt;

  // Command parameters only matter while a command is active, so they carry no reset.
  always_ff @(posedge clk) begin
    if (cmd_acc) begin
      dst_str <= bus.cmd_dst_str;
      beats   <= bus.cmd_beats;
    end
  end

  // Beat storage; the slot under rptr is never overwritten while occupied.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.axi_lsu_rdata;
  end

  // FIFO pointers and occupancy; reset discards any buffered beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  // Command sequencing, write addressing, beat counting and error capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_addr  <= '0;
      acc_cnt  <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
      err_resp <= 2'b00;
    end else begin
      if (push) begin
        acc_cnt <= acc_cnt + 8'd1;
        if (bus.axi_lsu_rresp != 2'b00) begin
          err <= 1'b1;
          if (!err) err_resp <= bus.axi_lsu_rresp;
        end
      end
      if (pop) begin
        wr_addr  <= wr_addr + dst_str;
        beat_cnt <= beat_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          if (bus.cmd_vld) begin
            wr_addr  <= bus.cmd_dst_addr;
            acc_cnt  <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
            err_resp <= 2'b00;
            state    <= (bus.cmd_beats == 8'd0) ? DONE : RECV;
          end
        end
        RECV: begin
          if (push && (acc_cnt + 8'd1 == beats)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && (count == ONE_CNT)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ld_collect.sv
// Directed bench for the load-data collector.
module tb_lsu_ld_collect;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_ld_collect_if #(.DW(64), .DST_AW(10)) bus();

  lsu_ld_collect #(.DW(64), .DST_AW(10), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit rrdy_seen;
  bit wren_seen;

  logic [63:0] feed_d [$];
  logic [1:0]  feed_r [$];
  logic [9:0]  exp_a  [$];
  logic [63:0] exp_d  [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present();
    bus.axi_lsu_rvld = (feed_d.size() != 0);
    bus.axi_lsu_rid  = 8'(feed_d.size());
    if (feed_d.size() != 0) begin
      bus.axi_lsu_rdata = feed_d[0];
      bus.axi_lsu_rresp = feed_r[0];
      bus.axi_lsu_rlast = (feed_d.size() == 1);
    end else begin
      bus.axi_lsu_rdata = '0;
      bus.axi_lsu_rresp = 2'b00;
      bus.axi_lsu_rlast = 1'b0;
    end
  endtask

  task automatic add_beat(input logic [63:0] d, input logic [1:0] r, input logic [9:0] a, input bit expect_wr);
    feed_d.push_back(d);
    feed_r.push_back(r);
    if (expect_wr) begin
      exp_a.push_back(a);
      exp_d.push_back(d);
    end
    present();
  endtask

  // One clock: observe handshakes before the edge, advance the beat source after it.
  task automatic cycle();
    logic acc;
    logic wr;
    acc = bus.axi_lsu_rvld & bus.lsu_axi_rrdy;
    wr  = bus.buf_wr_en & bus.buf_wr_rdy;
    if (bus.ld_done)      done_cnt++;
    if (bus.lsu_axi_rrdy) rrdy_seen = 1'b1;
    if (bus.buf_wr_en)    wren_seen = 1'b1;
    if (wr) begin
      if (exp_a.size() == 0) chk("stray_write", 64'd1, 64'd0);
      else begin
        chk("wr_addr", bus.buf_wr_addr, exp_a.pop_front());
        chk("wr_data", bus.buf_wr_data, exp_d.pop_front());
      end
    end
    @(posedge clk); #1;
    if (acc) begin
      void'(feed_d.pop_front());
      void'(feed_r.pop_front());
      present();
    end
  endtask

  task automatic issue(input logic [9:0] a, input logic [9:0] s, input logic [7:0] b);
    bus.cmd_vld      = 1'b1;
    bus.cmd_dst_addr = a;
    bus.cmd_dst_str  = s;
    bus.cmd_beats    = b;
    cycle();
    bus.cmd_vld      = 1'b0;
  endtask

  task automatic run_done(input string tag, input int bound);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < bound) begin
      cycle();
      n++;
    end
    chk({tag, "_done_pulse"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_writes_left"}, 64'(exp_a.size()), 64'd0);
    chk({tag, "_done_low"}, bus.ld_done, 1'b0);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_cmd_rdy"},  bus.cmd_rdy,      1'b1);
    chk({p, "_rrdy"},     bus.lsu_axi_rrdy, 1'b0);
    chk({p, "_wr_en"},    bus.buf_wr_en,    1'b0);
    chk({p, "_wr_addr"},  bus.buf_wr_addr,  10'h000);
    chk({p, "_done"},     bus.ld_done,      1'b0);
    chk({p, "_err"},      bus.ld_err,       1'b0);
    chk({p, "_err_resp"}, bus.ld_err_resp,  2'b00);
    chk({p, "_beat_cnt"}, bus.ld_beat_cnt,  8'd0);
  endtask

  initial begin
    int d0;
    bus.cmd_vld      = 1'b0;
    bus.cmd_dst_addr = '0;
    bus.cmd_dst_str  = '0;
    bus.cmd_beats    = '0;
    bus.buf_wr_rdy   = 1'b1;
    present();

    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    rst = 1'b0;

    // Contiguous load, beats already waiting, buffer always ready
    add_beat(64'h1111_0000_0000_00A1, 2'b00, 10'h010, 1'b1);
    add_beat(64'h2222_0000_0000_00A2, 2'b00, 10'h011, 1'b1);
    add_beat(64'h3333_0000_0000_00A3, 2'b00, 10'h012, 1'b1);
    add_beat(64'h4444_0000_0000_00A4, 2'b00, 10'h013, 1'b1);
    chk("t1_rrdy_idle", bus.lsu_axi_rrdy, 1'b0);
    issue(10'h010, 10'h001, 8'd4);
    run_done("t1", 30);
    chk("t1_beat_cnt", bus.ld_beat_cnt, 8'd4);
    chk("t1_err", bus.ld_err, 1'b0);
    cycle();
    chk("t1_single_pulse", 64'(done_cnt), 64'd1);

    // Stride 8 with buffer stalled for five cycles
    add_beat(64'hB0B0_0000_0000_0001, 2'b00, 10'h100, 1'b1);
    add_beat(64'hB1B1_0000_0000_0002, 2'b00, 10'h108, 1'b1);
    add_beat(64'hB2B2_0000_0000_0003, 2'b00, 10'h110, 1'b1);
    bus.buf_wr_rdy = 1'b0;
    issue(10'h100, 10'h008, 8'd3);
    cycle();
    cycle();
    chk("t2_rrdy_full", bus.lsu_axi_rrdy, 1'b0);
    chk("t2_wr_en", bus.buf_wr_en, 1'b1);
    chk("t2_addr_hold", bus.buf_wr_addr, 10'h100);
    chk("t2_data_hold", bus.buf_wr_data, 64'hB0B0_0000_0000_0001);
    cycle();
    cycle();
    chk("t2_rrdy_full2", bus.lsu_axi_rrdy, 1'b0);
    chk("t2_addr_hold2", bus.buf_wr_addr, 10'h100);
    chk("t2_data_hold2", bus.buf_wr_data, 64'hB0B0_0000_0000_0001);
    cycle();
    bus.buf_wr_rdy = 1'b1;
    run_done("t2", 30);
    chk("t2_beat_cnt", bus.ld_beat_cnt, 8'd3);

    // Address wrap at the top of the buffer
    add_beat(64'hC0C0_C0C0_0000_0001, 2'b00, 10'h3FC, 1'b1);
    add_beat(64'hC1C1_C1C1_0000_0002, 2'b00, 10'h000, 1'b1);
    add_beat(64'hC2C2_C2C2_0000_0003, 2'b00, 10'h004, 1'b1);
    issue(10'h3FC, 10'h004, 8'd3);
    run_done("t3", 30);
    chk("t3_beat_cnt", bus.ld_beat_cnt, 8'd3);

    // Error responses: first error captured, later one ignored, data still written
    add_beat(64'hD0D0_0000_0000_0001, 2'b00, 10'h040, 1'b1);
    add_beat(64'hD1D1_0000_0000_0002, 2'b10, 10'h042, 1'b1);
    add_beat(64'hD2D2_0000_0000_0003, 2'b01, 10'h044, 1'b1);
    issue(10'h040, 10'h002, 8'd3);
    run_done("t4", 30);
    chk("t4_err", bus.ld_err, 1'b1);
    chk("t4_err_resp", bus.ld_err_resp, 2'b10);
    chk("t4_beat_cnt", bus.ld_beat_cnt, 8'd3);

    // Zero-beat command with a beat pending upstream that must not be taken
    add_beat(64'hE0E0_E0E0_E0E0_E0E0, 2'b00, 10'h000, 1'b0);
    rrdy_seen = 1'b0;
    wren_seen = 1'b0;
    d0 = done_cnt;
    issue(10'h080, 10'h001, 8'd0);
    chk("t5_done", bus.ld_done, 1'b1);
    chk("t5_err_clear", bus.ld_err, 1'b0);
    chk("t5_resp_clear", bus.ld_err_resp, 2'b00);
    chk("t5_cnt_clear", bus.ld_beat_cnt, 8'd0);
    cycle();
    chk("t5_done_low", bus.ld_done, 1'b0);
    chk("t5_cmd_rdy", bus.cmd_rdy, 1'b1);
    cycle();
    chk("t5_one_pulse", 64'(done_cnt - d0), 64'd1);
    chk("t5_rrdy_never", rrdy_seen, 1'b0);
    chk("t5_wr_never", wren_seen, 1'b0);
    chk("t5_beat_pending", bus.axi_lsu_rvld, 1'b1);

    // Reset with one beat held in the FIFO mid-command
    bus.buf_wr_rdy = 1'b0;
    issue(10'h020, 10'h001, 8'd4);
    cycle();
    chk("t6_wr_en_pre", bus.buf_wr_en, 1'b1);
    chk("t6_addr_pre", bus.buf_wr_addr, 10'h020);
    chk("t6_cmd_busy", bus.cmd_rdy, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset("t6_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.buf_wr_rdy = 1'b1;
    wren_seen = 1'b0;
    repeat (4) cycle();
    chk("t6_no_write", wren_seen, 1'b0);
    chk("t6_addr_post", bus.buf_wr_addr, 10'h000);
    chk("t6_idle", bus.cmd_rdy, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
